synapse_array: RTL and testbench
================================

# synapse_array

Parametrised successor of the single-table synapse: a packed weight memory holding `N_SYN` weights of `W_BITS` each, stored `LANES = WORD_BITS/W_BITS` per word. It supports sequential bulk load, single-weight reads with registered output, and saturating STDP read-modify-write updates arbitrated by a small FSM. It sits between the spike decoder, which issues reads, and the STDP learning unit, which issues updates, in each neuron core.

## Interface
- `W_BITS`, 8, weight width (unsigned); must divide `WORD_BITS`
- `WORD_BITS`, 32, load/storage word width
- `N_SYN`, 128, number of synapses; multiple of `LANES`
- Derived: `LANES = WORD_BITS/W_BITS`, `DEPTH = N_SYN/LANES`, `AW = clog2(N_SYN)`, `LW = clog2(LANES)`
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `kill`  in  1  abort load/update, return to IDLE
- `load_en`  in  1  load beat valid
- `load_data`  in  WORD_BITS  packed weights; lane 0 = bits [W_BITS-1:0]
- `load_done`  out  1  one-cycle pulse after last word written
- `ready`  out  1  high in IDLE; rd/upd accepted only when high
- `rd_en`  in  1  read request
- `rd_addr`  in  AW  synapse index
- `rd_valid`  out  1  read data valid pulse
- `rd_weight`  out  W_BITS  read result
- `upd_en`  in  1  STDP update request
- `upd_addr`  in  AW  synapse index
- `upd_delta`  in  W_BITS  signed two's-complement delta
- `upd_done`  out  1  pulse when updated weight committed

## Operation
- Address split: word = `addr[AW-1:LW]`, lane = `addr[LW-1:0]` (no divide/modulo logic).
- FSM states: IDLE, LOAD, RMW_RD, RMW_WR.
- IDLE: `load_en` -> write `load_data` to word `load_cnt`, go to LOAD. Otherwise `upd_en` -> RMW_RD. Otherwise `rd_en` -> read. Priority: load > update > read; a losing request is dropped, not queued.
- LOAD: each `load_en` beat writes word `load_cnt` and increments it. Gaps (`load_en`=0) hold the count. The beat at `load_cnt == DEPTH-1` wraps the count to 0, pulses `load_done`, and returns to IDLE. `rd_en`/`upd_en` are ignored.
- RMW_RD: latch stored word and lane. Compute `sum = old + sext(upd_delta)` in W_BITS+2 bits. Clamp to [0, 2^W_BITS-1].
- RMW_WR: write back the full word with only the target lane replaced, pulse `upd_done`, go to IDLE.
- `kill`: any state -> IDLE, `load_cnt` <= 0. An in-flight RMW is discarded, so memory is unchanged unless the write already occurred. No `upd_done` or `load_done` is issued.
- `rst`: same as `kill`. Memory contents are not cleared and are undefined until a full load.
- Simultaneous `kill` and `rst`: `rst` dominates; the effect is identical.

## Timing
- Reset values: `ready`=1 (IDLE), `rd_valid`=0, `rd_weight`=0, `load_done`=0, `upd_done`=0, `load_cnt`=0.
- Read: accepted at edge t -> `rd_valid`=1 and `rd_weight` valid after edge t+1. Back-to-back reads give one result per cycle. `rd_weight` holds its last value when `rd_valid`=0.
- Update: accepted at t -> RMW_RD during t+1 -> write and `upd_done` at t+2 -> `ready` returns high at t+3.
- A read of the same address issued at t+3 returns the updated weight (no bypass needed).
- Load: one word per `load_en` cycle. `load_done` is registered in the cycle after the last write. A full load takes `DEPTH` beats minimum.
- `ready` is a registered function of state only (no input combinational path).

## Structure
- Package `synapse_pkg`: FSM state enum, `clog2`-derived width localparams as functions, and the saturating-add function.
- Sub-module `synapse_mem`: `DEPTH` x `WORD_BITS`, one write port, one registered-read port. Inferable as block RAM.
- The FSM, address split, lane mux/merge and saturation live in `synapse_array`.

## Test plan
- Bulk load with defaults: 32 words `0x03020100 + 0x04040404*i` -> `load_done` once after beat 31; read addr 5 -> `0x05`, addr 127 -> `0x7F`, each one cycle after the request.
- Saturation: weight `0xF0`, delta `+0x20` -> `0xFF`; weight `0x10`, delta `-0x30` (`0xD0`) -> `0x00`; `upd_done` at t+2 and neighbouring lanes unchanged.
- Priority/drop: `upd_en` and `rd_en` in the same IDLE cycle -> update performed, no `rd_valid`; `rd_en` during RMW_RD -> ignored.
- Load with gaps plus `kill` mid-load after 10 beats -> IDLE with `ready`=1; a new load restarts at word 0 and needs 32 beats for `load_done`.
- `rst` asserted in RMW_RD -> no `upd_done`; target weight still holds its old value on a subsequent read.
- Parameter sweep `W_BITS`=16, `WORD_BITS`=64, `N_SYN`=64 -> load, read and saturate (`0xFFFF`) behave identically.

Source files
------------

// File: rtl/synapse_pkg.sv
// rtl/synapse_pkg.sv - shared types, width helpers and saturating add for the synapse array
package synapse_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    localparam int SAT_W = 64;

    function automatic int lanes_of(input int word_bits, input int w_bits);
        return word_bits / w_bits;
    endfunction

    function automatic int depth_of(input int n_syn, input int lanes);
        return n_syn / lanes;
    endfunction

    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

    // old is unsigned, delta_sx is already sign-extended; two guard bits keep the sign and the carry.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] old_w,
                                                 input logic [SAT_W-1:0] delta_sx,
                                                 input int w_bits);
        logic [SAT_W+1:0] sum;
        sum = {2'b00, old_w} + {{2{delta_sx[SAT_W-1]}}, delta_sx};
        if (sum[SAT_W+1]) begin
            return '0;
        end else if ((sum >> w_bits) != '0) begin
            return ~({SAT_W{1'b1}} << w_bits);
        end else begin
            return sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/synapse_mem.sv
// rtl/synapse_mem.sv - single write port, registered read port word memory
module synapse_mem #(
    parameter int DEPTH     = 32,
    parameter int WORD_BITS = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/synapse_array.sv
// rtl/synapse_array.sv - packed weight memory with bulk load, reads and saturating STDP updates
module synapse_array
    import synapse_pkg::*;
#(
    parameter int  W_BITS    = 8,
    parameter int  WORD_BITS = 32,
    parameter int  N_SYN     = 128,
    localparam int LANES     = lanes_of(WORD_BITS, W_BITS),
    localparam int DEPTH     = depth_of(N_SYN, LANES),
    localparam int AW        = addr_width(N_SYN),
    localparam int LW        = addr_width(LANES),
    localparam int DW        = AW - LW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kill,
    input  logic                 load_en,
    input  logic [WORD_BITS-1:0] load_data,
    output logic                 load_done,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_valid,
    output logic [W_BITS-1:0]    rd_weight,
    input  logic                 upd_en,
    input  logic [AW-1:0]        upd_addr,
    input  logic [W_BITS-1:0]    upd_delta,
    output logic                 upd_done
);

    state_t                         state, state_next;
    logic [DW-1:0]                  load_cnt;
    logic                           load_last, load_beat, upd_go, rd_go, rd_pend;
    logic [LW-1:0]                  lane_r;
    logic [DW-1:0]                  rmw_word;
    logic [W_BITS-1:0]              delta_r;
    logic [WORD_BITS-1:0]           merged_r;
    logic                           mem_we, mem_re;
    logic [DW-1:0]                  mem_waddr, mem_raddr;
    logic [WORD_BITS-1:0]           mem_wdata, mem_rdata;
    logic [LANES-1:0][W_BITS-1:0]   word_lanes, merged;
    logic [W_BITS-1:0]              new_lane;

    assign load_last = (load_cnt == DW'(DEPTH - 1));

    always_comb begin
        state_next = state;
        load_beat  = 1'b0;
        upd_go     = 1'b0;
        rd_go      = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_en) begin
                    load_beat  = 1'b1;
                    state_next = load_last ? S_IDLE : S_LOAD;
                end else if (upd_en) begin
                    upd_go     = 1'b1;
                    state_next = S_RMW_RD;
                end else if (rd_en) begin
                    rd_go = 1'b1;
                end
            end
            S_LOAD: begin
                if (load_en) begin
                    load_beat = 1'b1;
                    if (load_last) state_next = S_IDLE;
                end
            end
            S_RMW_RD: state_next = S_RMW_WR;
            S_RMW_WR: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (kill) begin
            state_next = S_IDLE;
            load_beat  = 1'b0;
            upd_go     = 1'b0;
            rd_go      = 1'b0;
        end
    end

    // A kill or reset on the write-back edge drops the write entirely.
    assign mem_we    = !rst && !kill && (load_beat || state == S_RMW_WR);
    assign mem_waddr = (state == S_RMW_WR) ? rmw_word : load_cnt;
    assign mem_wdata = (state == S_RMW_WR) ? merged_r : load_data;
    assign mem_re    = upd_go || rd_go;
    assign mem_raddr = upd_go ? upd_addr[AW-1:LW] : rd_addr[AW-1:LW];

    always_comb begin
        word_lanes     = mem_rdata;
        new_lane       = W_BITS'(sat_add(SAT_W'(word_lanes[lane_r]), SAT_W'($signed(delta_r)), W_BITS));
        merged         = word_lanes;
        merged[lane_r] = new_lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            ready     <= 1'b1;
            load_done <= 1'b0;
            upd_done  <= 1'b0;
            rd_pend   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_weight <= '0;
        end else begin
            state     <= state_next;
            ready     <= (state_next == S_IDLE);
            load_done <= load_beat && load_last;
            upd_done  <= (state == S_RMW_WR) && !kill;
            rd_pend   <= rd_go;
            rd_valid  <= rd_pend;
            if (rd_pend) rd_weight <= word_lanes[lane_r];
            if (kill) begin
                load_cnt <= '0;
            end else if (load_beat) begin
                load_cnt <= load_last ? '0 : load_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_go) begin
            lane_r   <= upd_addr[LW-1:0];
            rmw_word <= upd_addr[AW-1:LW];
            delta_r  <= upd_delta;
        end else if (rd_go) begin
            lane_r <= rd_addr[LW-1:0];
        end
        if (state == S_RMW_RD) merged_r <= merged;
    end

    synapse_mem #(
        .DEPTH     (DEPTH),
        .WORD_BITS (WORD_BITS),
        .ADDR_W    (DW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_synapse_array.sv
// tb/tb_synapse_array.sv - scoreboard bench for two synapse_array configurations
module tb_synapse_array;

    typedef struct {
        int              cyc;
        longint unsigned val;
    } exp_t;

    logic        clk, rst, kill;
    logic        a_load_en, a_load_done, a_ready, a_rd_en, a_rd_valid, a_upd_en, a_upd_done;
    logic [31:0] a_load_data;
    logic [6:0]  a_rd_addr, a_upd_addr;
    logic [7:0]  a_rd_weight, a_upd_delta;
    logic        b_load_en, b_load_done, b_ready, b_rd_en, b_rd_valid, b_upd_en, b_upd_done;
    logic [63:0] b_load_data;
    logic [5:0]  b_rd_addr, b_upd_addr;
    logic [15:0] b_rd_weight, b_upd_delta;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   model_a [128];
    int   model_b [64];
    int   m_cnt [2];
    exp_t q_rd_a[$], q_upd_a[$], q_ld_a[$], q_rd_b[$], q_upd_b[$], q_ld_b[$];

    synapse_array u_a (
        .clk(clk), .rst(rst), .kill(kill),
        .load_en(a_load_en), .load_data(a_load_data), .load_done(a_load_done), .ready(a_ready),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_valid(a_rd_valid), .rd_weight(a_rd_weight),
        .upd_en(a_upd_en), .upd_addr(a_upd_addr), .upd_delta(a_upd_delta), .upd_done(a_upd_done)
    );

    synapse_array #(.W_BITS(16), .WORD_BITS(64), .N_SYN(64)) u_b (
        .clk(clk), .rst(rst), .kill(kill),
        .load_en(b_load_en), .load_data(b_load_data), .load_done(b_load_done), .ready(b_ready),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_weight(b_rd_weight),
        .upd_en(b_upd_en), .upd_addr(b_upd_addr), .upd_delta(b_upd_delta), .upd_done(b_upd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wmax(input bit b);
        return b ? 32'hFFFF : 32'hFF;
    endfunction

    // Scoreboard monitors: every output pulse must match the oldest expectation in cycle and value.
    always @(negedge clk) begin : mon
        exp_t e;
        if (a_rd_valid) begin
            if (q_rd_a.size() == 0) chk("a_rd_spurious", a_rd_valid, 0);
            else begin e = q_rd_a.pop_front(); chk("a_rd_cyc", cyc, e.cyc); chk("a_rd_weight", a_rd_weight, e.val); end
        end
        if (a_upd_done) begin
            if (q_upd_a.size() == 0) chk("a_upd_spurious", a_upd_done, 0);
            else begin e = q_upd_a.pop_front(); chk("a_upd_cyc", cyc, e.cyc); end
        end
        if (a_load_done) begin
            if (q_ld_a.size() == 0) chk("a_ld_spurious", a_load_done, 0);
            else begin e = q_ld_a.pop_front(); chk("a_ld_cyc", cyc, e.cyc); end
        end
        if (b_rd_valid) begin
            if (q_rd_b.size() == 0) chk("b_rd_spurious", b_rd_valid, 0);
            else begin e = q_rd_b.pop_front(); chk("b_rd_cyc", cyc, e.cyc); chk("b_rd_weight", b_rd_weight, e.val); end
        end
        if (b_upd_done) begin
            if (q_upd_b.size() == 0) chk("b_upd_spurious", b_upd_done, 0);
            else begin e = q_upd_b.pop_front(); chk("b_upd_cyc", cyc, e.cyc); end
        end
        if (b_load_done) begin
            if (q_ld_b.size() == 0) chk("b_ld_spurious", b_load_done, 0);
            else begin e = q_ld_b.pop_front(); chk("b_ld_cyc", cyc, e.cyc); end
        end
    end

    task automatic do_load(input bit b, input logic [63:0] data);
        exp_t e;
        int   depth = b ? 16 : 32;
        int   w = b ? 16 : 8;
        for (int l = 0; l < 4; l++) begin
            int v = int'((data >> (l * w)) & 64'(wmax(b)));
            if (b) model_b[m_cnt[1] * 4 + l] = v;
            else   model_a[m_cnt[0] * 4 + l] = v;
        end
        if (m_cnt[b] == depth - 1) begin
            e.cyc = cyc + 1;
            e.val = 0;
            if (b) q_ld_b.push_back(e); else q_ld_a.push_back(e);
            m_cnt[b] = 0;
        end else begin
            m_cnt[b]++;
        end
        if (b) begin b_load_en = 1'b1; b_load_data = data; end
        else   begin a_load_en = 1'b1; a_load_data = data[31:0]; end
        tick();
        a_load_en = 1'b0;
        b_load_en = 1'b0;
    endtask

    task automatic do_read(input bit b, input int addr);
        exp_t e;
        e.cyc = cyc + 2;
        if (b) begin
            e.val = longint'(model_b[addr]);
            q_rd_b.push_back(e);
            b_rd_en = 1'b1; b_rd_addr = 6'(addr);
        end else begin
            e.val = longint'(model_a[addr]);
            q_rd_a.push_back(e);
            a_rd_en = 1'b1; a_rd_addr = 7'(addr);
        end
        tick();
        a_rd_en = 1'b0;
        b_rd_en = 1'b0;
    endtask

    // delta is the signed value; the model clamps plain integer arithmetic to the weight range.
    task automatic do_update(input bit b, input int addr, input int delta, input bit also_rd);
        exp_t e;
        int   old_w = b ? model_b[addr] : model_a[addr];
        int   new_w = old_w + delta;
        if (new_w < 0) new_w = 0;
        if (new_w > wmax(b)) new_w = wmax(b);
        if (b) model_b[addr] = new_w; else model_a[addr] = new_w;
        e.cyc = cyc + 3;
        e.val = 0;
        if (b) begin
            q_upd_b.push_back(e);
            b_upd_en = 1'b1; b_upd_addr = 6'(addr); b_upd_delta = 16'(delta);
            b_rd_en = also_rd; b_rd_addr = 6'($urandom_range(0, 63));
        end else begin
            q_upd_a.push_back(e);
            a_upd_en = 1'b1; a_upd_addr = 7'(addr); a_upd_delta = 8'(delta);
            a_rd_en = also_rd; a_rd_addr = 7'($urandom_range(0, 127));
        end
        tick();
        a_upd_en = 1'b0;
        b_upd_en = 1'b0;
        chk("ready_busy", b ? b_ready : a_ready, 0);
        tick();
        a_rd_en = 1'b0;
        b_rd_en = 1'b0;
        tick();
        chk("ready_back", b ? b_ready : a_ready, 1);
    endtask

    task automatic random_ops(input bit b, input int n);
        int amax = b ? 63 : 127;
        int hw = b ? 32768 : 128;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: do_read(b, $urandom_range(0, amax));
                1: do_update(b, $urandom_range(0, amax), $urandom_range(0, 2 * hw - 1) - hw, 1'($urandom_range(0, 1)));
                default: repeat (3) do_read(b, $urandom_range(0, amax));
            endcase
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int addr_rst;
        rst = 1'b1; kill = 1'b0;
        a_load_en = 0; a_load_data = 0; a_rd_en = 0; a_rd_addr = 0; a_upd_en = 0; a_upd_addr = 0; a_upd_delta = 0;
        b_load_en = 0; b_load_data = 0; b_rd_en = 0; b_rd_addr = 0; b_upd_en = 0; b_upd_addr = 0; b_upd_delta = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        repeat (3) tick();
        chk("rst_ready", a_ready, 1);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_weight", a_rd_weight, 0);
        chk("rst_load_done", a_load_done, 0);
        chk("rst_upd_done", a_upd_done, 0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_rd_weight", b_rd_weight, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 32; i++) do_load(0, 64'(32'h03020100 + 32'h04040404 * i));
        do_read(0, 5);
        do_read(0, 127);
        for (int i = 0; i < 8; i++) do_read(0, $urandom_range(0, 127));

        do_update(0, 112, 127, 0);
        do_update(0, 112, 1, 0);
        do_update(0, 112, 32, 0);
        do_update(0, 16, -48, 0);
        foreach (model_a[i]) if (i == 111 || i == 112 || i == 113 || i == 15 || i == 16 || i == 17) do_read(0, i);

        do_update(0, $urandom_range(0, 127), 5, 1);
        random_ops(0, 60);

        for (int i = 0; i < 10; i++) begin
            do_load(0, 64'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        chk("kill_ready", a_ready, 1);
        for (int i = 0; i < 32; i++) begin
            do_load(0, 64'($urandom));
            if (i < 31) repeat ($urandom_range(0, 2)) tick();
        end
        for (int i = 0; i < 12; i++) do_read(0, $urandom_range(0, 127));

        addr_rst = $urandom_range(0, 127);
        a_upd_en = 1'b1; a_upd_addr = 7'(addr_rst); a_upd_delta = 8'h05;
        tick();
        a_upd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        chk("rst_rmw_ready", a_ready, 1);
        tick();
        do_read(0, addr_rst);

        do_load(1, 64'h1234_0010_FFF0_0005);
        for (int i = 1; i < 16; i++) do_load(1, {$urandom, $urandom});
        for (int i = 0; i < 4; i++) do_read(1, i);
        do_update(1, 1, 32, 0);
        do_update(1, 2, -48, 0);
        do_update(1, 1, 32767, 0);
        for (int i = 0; i < 4; i++) do_read(1, i);
        random_ops(1, 25);

        repeat (6) tick();
        chk("drain_rd_a", q_rd_a.size(), 0);
        chk("drain_upd_a", q_upd_a.size(), 0);
        chk("drain_ld_a", q_ld_a.size(), 0);
        chk("drain_rd_b", q_rd_b.size(), 0);
        chk("drain_upd_b", q_upd_b.size(), 0);
        chk("drain_ld_b", q_ld_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
